uart_tx_fifo: RTL and testbench

//  Transmit byte buffer between the CPU bus write path and the UART sender.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_txf_mem.sv | 23 ++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register addresses for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_WAIT_BUSY,
    TXF_WAIT_DONE
  } txf_state_t;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

endpackage

// File: rtl/uart_txf_mem.sv
// Transmit FIFO storage: DEPTH x 8 register array.
// One synchronous write port and one asynchronous read port.
module uart_txf_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [DEPTH-1:0][7:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-to-UART transmit byte FIFO feeding the sender through its txen/txstatus handshake.
// Define UART_TXF_IRQ_EN to add the low-water irq output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int LOW_WATER = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            clr_overflow,
  output logic [7:0]      tx_data,
  output logic            tx_en,
  input  logic            tx_status,
  output logic            busy
`ifdef UART_TXF_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must equal 2**ADDR_W");
  end
  if (LOW_WATER < 1 || LOW_WATER > DEPTH) begin : g_bad_lw
    $error("uart_tx_fifo: LOW_WATER out of range");
  end

  txf_state_t        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d, head;
  logic              tx_en_q, tx_en_d;
  logic              ovf_q, ovf_d;
  logic              pop, push, drop;

  uart_txf_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign busy  = (state_q != TXF_IDLE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      TXF_IDLE: begin
        if (!empty && tx_status) begin
          pop     = 1'b1;
          state_d = TXF_WAIT_BUSY;
        end
      end
      TXF_WAIT_BUSY: if (!tx_status) state_d = TXF_WAIT_DONE;
      TXF_WAIT_DONE: if (tx_status)  state_d = TXF_IDLE;
      default:       state_d = TXF_IDLE;
    endcase
  end

  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  always_comb begin
    push      = wr_en && (!full || pop);
    drop      = wr_en && full && !pop;
    tx_en_d   = pop;
    tx_data_d = pop ? head : tx_data_q;
    ovf_d     = drop | (ovf_q & ~clr_overflow);
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= TXF_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign overflow = ovf_q;

`ifdef UART_TXF_IRQ_EN
  localparam logic [ADDR_W:0] LW_CNT = (ADDR_W+1)'(LOW_WATER);

  logic irq_q, irq_d;

  // Raise only when draining through the threshold; refilling to it clears.
  always_comb begin
    irq_d = irq_q;
    if (pop && !push && count_q == LW_CNT)
      irq_d = 1'b1;
    else if (push && !pop && count_d >= LW_CNT)
      irq_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int N_BUSY = 20;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_overflow = 1'b0;
  logic              tx_status;
  logic              full, empty, overflow, tx_en, busy;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_data;
`ifdef UART_TXF_IRQ_EN
  logic              irq;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOW_WATER(4)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_status    (tx_status),
    .busy         (busy)
`ifdef UART_TXF_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 CLK = ~CLK;

  // Sender model: drops tx_status the cycle after tx_en, idle again N_BUSY later.
  logic hold_low = 1'b1;
  int   busy_cnt;
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      tx_status <= 1'b1;
      busy_cnt  <= 0;
    end else if (hold_low) begin
      tx_status <= 1'b0;
    end else if (tx_en) begin
      tx_status <= 1'b0;
      busy_cnt  <= N_BUSY;
    end else if (busy_cnt > 1) begin
      busy_cnt  <= busy_cnt - 1;
    end else begin
      busy_cnt  <= 0;
      tx_status <= 1'b1;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || !tx_status) && n < budget) begin
      step();
      n++;
    end
    chk("idle wait busy", {31'b0, busy}, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Reference model: plain byte queue plus sticky overflow bit.
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       prev_en, prev_st;

  task automatic model_cycle(input logic wr, input logic [7:0] d, input logic clr);
    logic       pop_now, full_pre, accepted;
    logic [7:0] e;
    pop_now  = (tx_en === 1'b1);
    full_pre = (mq.size() == DEPTH);
    if (pop_now) begin
      chk("rnd launch after idle sender", {31'b0, prev_st}, 1);
      chk("rnd launch not back-to-back", {31'b0, prev_en}, 0);
      if (mq.size() == 0) begin
        chk("rnd launch with empty model", 1, 0);
      end else begin
        e = mq.pop_front();
        chk("rnd tx_data", {24'b0, tx_data}, {24'b0, e});
      end
    end
    accepted = wr && (!full_pre || pop_now);
    if (accepted) mq.push_back(d);
    if (wr && full_pre && !pop_now) m_ovf = 1'b1;
    else if (clr)                   m_ovf = 1'b0;
    chk("rnd count", {27'b0, count}, mq.size());
    chk("rnd overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("rnd full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    chk("rnd empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    prev_en = tx_en;
    prev_st = tx_status;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    int         cnt;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t       vec[20];
  logic [7:0] exp_bytes[$];
  int         k, launches;
  logic       saw_rise, prev_stat_d, done;
  logic       r_wr, r_clr;
  logic [7:0] r_d;

  initial begin
    // Vector table: sender held busy so nothing launches while filling.
    for (int i = 0; i < 16; i++)
      vec[i] = '{1'b1, 8'h10 + 8'(i), 1'b0, i + 1, (i == 15), 1'b0};
    vec[16] = '{1'b1, 8'hF0, 1'b0, 16, 1'b1, 1'b1};
    vec[17] = '{1'b1, 8'hF1, 1'b1, 16, 1'b1, 1'b1};
    vec[18] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
    vec[19] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0};

    step();
    chk("reset count", {27'b0, count}, 0);
    chk("reset empty", {31'b0, empty}, 1);
    chk("reset full", {31'b0, full}, 0);
    chk("reset tx_en", {31'b0, tx_en}, 0);
    chk("reset tx_data", {24'b0, tx_data}, 0);
    chk("reset overflow", {31'b0, overflow}, 0);
    chk("reset busy", {31'b0, busy}, 0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      wr_en = vec[i].wr; wr_data = vec[i].data; clr_overflow = vec[i].clr;
      step();
      chk($sformatf("vec%0d count", i), {27'b0, count}, vec[i].cnt);
      chk($sformatf("vec%0d full", i), {31'b0, full}, {31'b0, vec[i].full});
      chk($sformatf("vec%0d empty", i), {31'b0, empty}, 0);
      chk($sformatf("vec%0d overflow", i), {31'b0, overflow}, {31'b0, vec[i].ovf});
      chk($sformatf("vec%0d tx_en", i), {31'b0, tx_en}, 0);
    end
    wr_en = 1'b0; clr_overflow = 1'b0;

    // Push on the very cycle the full FIFO launches its head.
    hold_low = 1'b0;
    step();
    chk("pre-launch tx_en", {31'b0, tx_en}, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("full-launch tx_en", {31'b0, tx_en}, 1);
    chk("full-launch tx_data", {24'b0, tx_data}, 8'h10);
    chk("full-launch count", {27'b0, count}, 16);
    chk("full-launch full", {31'b0, full}, 1);
    chk("full-launch overflow", {31'b0, overflow}, 0);

    for (int i = 1; i < 16; i++) exp_bytes.push_back(8'h10 + 8'(i));
    exp_bytes.push_back(8'hEE);
    k = 0; saw_rise = 1'b0; prev_stat_d = tx_status;
    for (int c = 0; c < 1200 && k < 16; c++) begin
      step();
      if (!prev_stat_d && tx_status) saw_rise = 1'b1;
      prev_stat_d = tx_status;
      if (tx_en) begin
        chk($sformatf("drain%0d data", k), {24'b0, tx_data}, {24'b0, exp_bytes[k]});
        chk($sformatf("drain%0d after sender rise", k), {31'b0, saw_rise}, 1);
        saw_rise = 1'b0;
        k++;
      end
    end
    chk("drain launches", k, 16);
    wait_idle(200);
    chk("drain final count", {27'b0, count}, 0);

    // Single byte into an empty FIFO.
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("a5 queued count", {27'b0, count}, 1);
    chk("a5 no launch yet", {31'b0, tx_en}, 0);
    step();
    chk("a5 tx_en", {31'b0, tx_en}, 1);
    chk("a5 tx_data", {24'b0, tx_data}, 8'hA5);
    chk("a5 count", {27'b0, count}, 0);
    chk("a5 busy", {31'b0, busy}, 1);
    step();
    chk("a5 pulse width", {31'b0, tx_en}, 0);
    wait_idle(200);

    // Reset while waiting for the sender to finish, with bytes still queued.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    step();
    chk("midrst pre count", {27'b0, count}, 5);
    chk("midrst pre busy", {31'b0, busy}, 1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst count", {27'b0, count}, 0);
    chk("midrst empty", {31'b0, empty}, 1);
    chk("midrst tx_en", {31'b0, tx_en}, 0);
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst tx_data", {24'b0, tx_data}, 0);
    step();
    Reset = 1'b0;
    launches = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (tx_en) launches++;
    end
    chk("midrst no relaunch", launches, 0);

    // Randomized traffic against the queue model.
    do_reset();
    mq.delete(); m_ovf = 1'b0; prev_en = 1'b0; prev_st = tx_status;
    for (int c = 0; c < 1500; c++) begin
      r_wr  = ($urandom_range(0, 99) < ((c < 700) ? 45 : 4));
      r_d   = 8'($urandom);
      r_clr = ($urandom_range(0, 15) == 0);
      wr_en = r_wr; wr_data = r_d; clr_overflow = r_clr;
      step();
      model_cycle(r_wr, r_d, r_clr);
    end
    wr_en = 1'b0; clr_overflow = 1'b0;
    for (int c = 0; c < 2000 && (mq.size() != 0 || busy); c++) begin
      step();
      model_cycle(1'b0, 8'h00, 1'b0);
    end
    chk("rnd drained", mq.size(), 0);

`ifdef UART_TXF_IRQ_EN
    do_reset();
    hold_low = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("irq fill count", {27'b0, count}, 6);
    chk("irq fill low", {31'b0, irq}, 0);
    hold_low = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      step();
      if (tx_en) begin
        if (count == 3) begin
          chk("irq rise", {31'b0, irq}, 1);
          wr_en = 1'b1; wr_data = 8'h77;
          step();
          wr_en = 1'b0;
          chk("irq refill count", {27'b0, count}, 4);
          chk("irq cleared", {31'b0, irq}, 0);
          done = 1'b1;
        end else begin
          chk($sformatf("irq low at count %0d", count), {31'b0, irq}, 0);
        end
      end
    end
    chk("irq sequence done", {31'b0, done}, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
